fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the PC next-address logic.
- Holds the architectural fetch PC, issues one-at-a-time requests to instruction memory, and buffers returned instructions with their PCs toward decode.
- On PC_clear (taken branch/jump resolved downstream), loads PC_next, flushes buffered instructions and discards any in-flight response.

---
 rtl/fetch_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting directly upstream of the PC next-address
// logic. It owns the architectural fetch PC, issues one request at a time to
// instruction memory, and buffers returned instructions (with their PCs) in a
// small FIFO that feeds decode. A redirect strobe (PC_clear) reloads the fetch
// PC, flushes the FIFO and causes any in-flight response to be dropped.
//
// Ports:
//   clk         in   clock, all state updates on the rising edge
//   reset       in   synchronous active-high reset
//   PC_next     in   redirect target from the next-address logic
//   PC_clear    in   redirect / flush strobe (one cycle per event)
//   imem_req    out  memory request valid
//   imem_addr   out  memory request address (current fetch PC)
//   imem_ready  in   memory accepts the request when imem_req & imem_ready
//   imem_valid  in   memory response valid (one per accepted request)
//   imem_data   in   memory response instruction word
//   dec_valid   out  FIFO head is valid
//   dec_instr   out  FIFO head instruction
//   dec_pc      out  PC of the FIFO head instruction
//   dec_ready   in   decode consumes the head when dec_valid & dec_ready
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int ADDRESS_SIZE     = 32,
    parameter int INSTRUCTION_SIZE = 4,
    parameter int DATA_SIZE        = 32,
    parameter int BUFFER_DEPTH     = 2,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC = {ADDRESS_SIZE{1'b0}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDRESS_SIZE-1:0] PC_next,
    input  logic                    PC_clear,
    output logic                    imem_req,
    output logic [ADDRESS_SIZE-1:0] imem_addr,
    input  logic                    imem_ready,
    input  logic                    imem_valid,
    input  logic [DATA_SIZE-1:0]    imem_data,
    output logic                    dec_valid,
    output logic [DATA_SIZE-1:0]    dec_instr,
    output logic [ADDRESS_SIZE-1:0] dec_pc,
    input  logic                    dec_ready
);

    localparam int PTR_W = $clog2(BUFFER_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDRESS_SIZE-1:0] PC_STEP    = ADDRESS_SIZE'(INSTRUCTION_SIZE);
    localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ~(ADDRESS_SIZE'(INSTRUCTION_SIZE - 1));
    localparam logic [CNT_W-1:0]        FULL_COUNT = CNT_W'(BUFFER_DEPTH);
    localparam logic [CNT_W-1:0]        CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0]        PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]        PTR_ONE    = PTR_W'(1'b1);

    // REQ: may issue; WAIT: one outstanding, response kept;
    // DRAIN: one outstanding, response will be discarded.
    typedef enum logic [1:0] {
        ST_REQ   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_DRAIN = 2'b10
    } fetch_state_t;

    // Redirect targets are forced onto an instruction boundary.
    function automatic logic [ADDRESS_SIZE-1:0] align_pc(input logic [ADDRESS_SIZE-1:0] pc);
        return pc & ALIGN_MASK;
    endfunction

    // Sequential successor; wraps silently at the top of the address space.
    function automatic logic [ADDRESS_SIZE-1:0] seq_pc(input logic [ADDRESS_SIZE-1:0] pc);
        return pc + PC_STEP;
    endfunction

    fetch_state_t            state_r;
    fetch_state_t            state_s;
    logic [ADDRESS_SIZE-1:0] fetch_pc_r;
    logic [ADDRESS_SIZE-1:0] fetch_pc_s;
    logic [ADDRESS_SIZE-1:0] pending_pc_r;
    logic [ADDRESS_SIZE-1:0] pending_pc_s;

    logic [DATA_SIZE-1:0]    instr_mem_r [BUFFER_DEPTH];
    logic [ADDRESS_SIZE-1:0] pc_mem_r    [BUFFER_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_s;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        wr_ptr_s;
    logic [CNT_W-1:0]        count_r;
    logic [CNT_W-1:0]        count_s;

    logic req_s;
    logic accept_s;
    logic push_s;
    logic pop_s;
    logic head_valid_s;

    // Request / handshake qualifiers. A request is only issued when a FIFO
    // slot is free, so the eventual push can never overflow.
    always_comb begin
        req_s        = 1'b0;
        accept_s     = 1'b0;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        head_valid_s = 1'b0;
        if (reset) begin
            req_s        = 1'b0;
            head_valid_s = 1'b0;
        end else begin
            req_s        = (state_r == ST_REQ) && (count_r < FULL_COUNT) && !PC_clear;
            head_valid_s = (count_r != CNT_ZERO);
        end
        accept_s = req_s && imem_ready;
        // A redirect overrides both the push of a kept response and a pop.
        push_s   = (state_r == ST_WAIT) && imem_valid && !PC_clear && !reset;
        pop_s    = head_valid_s && dec_ready && !PC_clear;
    end

    // Next-state logic for the fetch FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_REQ: begin
                if (PC_clear) begin
                    state_s = ST_REQ;
                end else if (accept_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                // A response arriving with a redirect is simply dropped.
                if (imem_valid) begin
                    state_s = ST_REQ;
                end else if (PC_clear) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (imem_valid) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_REQ;
            end
        endcase
    end

    // Fetch PC and pending (issued) PC update; redirect has highest priority.
    always_comb begin
        fetch_pc_s   = fetch_pc_r;
        pending_pc_s = pending_pc_r;
        if (PC_clear) begin
            fetch_pc_s = align_pc(PC_next);
        end else if (accept_s) begin
            fetch_pc_s   = seq_pc(fetch_pc_r);
            pending_pc_s = fetch_pc_r;
        end else begin
            fetch_pc_s = fetch_pc_r;
        end
    end

    // FIFO pointer and occupancy update; a redirect empties the FIFO.
    always_comb begin
        rd_ptr_s = rd_ptr_r;
        wr_ptr_s = wr_ptr_r;
        count_s  = count_r;
        if (PC_clear) begin
            rd_ptr_s = PTR_ZERO;
            wr_ptr_s = PTR_ZERO;
            count_s  = CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + CNT_ONE;
                2'b01:   count_s = count_r - CNT_ONE;
                default: count_s = count_r;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_REQ;
            fetch_pc_r   <= RESET_PC;
            pending_pc_r <= RESET_PC;
            rd_ptr_r     <= PTR_ZERO;
            wr_ptr_r     <= PTR_ZERO;
            count_r      <= CNT_ZERO;
        end else begin
            state_r      <= state_s;
            fetch_pc_r   <= fetch_pc_s;
            pending_pc_r <= pending_pc_s;
            rd_ptr_r     <= rd_ptr_s;
            wr_ptr_r     <= wr_ptr_s;
            count_r      <= count_s;
        end
    end

    // FIFO storage; contents are don't-care while the occupancy is zero.
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_r[wr_ptr_r] <= imem_data;
            pc_mem_r[wr_ptr_r]    <= pending_pc_r;
        end else begin
            instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
            pc_mem_r[wr_ptr_r]    <= pc_mem_r[wr_ptr_r];
        end
    end

    assign imem_req  = req_s;
    assign imem_addr = fetch_pc_r;
    assign dec_valid = head_valid_s;
    assign dec_instr = instr_mem_r[rd_ptr_r];
    assign dec_pc    = pc_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A behavioural instruction memory with a
// configurable response latency answers requests; expected {pc, instr} pairs
// are queued when a response is handed to the DUT and compared against the
// decode-side head. Per-scenario tasks add targeted checks on top.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic [31:0] PC_next;
    logic        PC_clear;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;

    fetch_unit #(
        .ADDRESS_SIZE(32),
        .INSTRUCTION_SIZE(4),
        .DATA_SIZE(32),
        .BUFFER_DEPTH(DEPTH),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .PC_next(PC_next),
        .PC_clear(PC_clear),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_valid(imem_valid),
        .imem_data(imem_data),
        .dec_valid(dec_valid),
        .dec_instr(dec_instr),
        .dec_pc(dec_pc),
        .dec_ready(dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // memory model / reference state
    bit          mem_busy = 1'b0;
    bit          mem_discard = 1'b0;
    int          mem_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] mem_addr_q = 32'h0;
    logic [31:0] model_pc = 32'h0;
    exp_t        exp_q[$];
    logic [31:0] cons_pc[$];
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];

    // snapshots of the last sampled cycle
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_dvalid;
    logic [31:0] s_dpc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    // One clock cycle: drive memory response, sample, score, advance model.
    task automatic run_cycle();
        bit   drive_valid;
        logic exp_req;
        exp_t e;
        drive_valid = 1'b0;
        if (reset) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt <= 0) drive_valid = 1'b1;
        end
        imem_valid = drive_valid;
        imem_data  = drive_valid ? mem_word(mem_addr_q) : 32'hDEAD_BEEF;
        #1;
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_dvalid = dec_valid;
        s_dpc    = dec_pc;

        exp_req = !reset && !mem_busy && (exp_q.size() < DEPTH) && !PC_clear;
        checks++;
        if (imem_req !== exp_req) begin
            errors++;
            $display("FAIL imem_req cyc=%0d: got %b expected %b", cyc, imem_req, exp_req);
        end
        checks++;
        if (dec_valid !== (!reset && exp_q.size() > 0)) begin
            errors++;
            $display("FAIL dec_valid cyc=%0d: got %b expected %b", cyc, dec_valid,
                     (!reset && exp_q.size() > 0));
        end
        if (dec_valid === 1'b1 && exp_q.size() > 0) begin
            checks++;
            if (dec_pc !== exp_q[0].pc) begin
                errors++;
                $display("FAIL dec_pc cyc=%0d: got %h expected %h", cyc, dec_pc, exp_q[0].pc);
            end
            checks++;
            if (dec_instr !== exp_q[0].data) begin
                errors++;
                $display("FAIL dec_instr cyc=%0d: got %h expected %h", cyc, dec_instr, exp_q[0].data);
            end
        end
        if (imem_req === 1'b1) begin
            checks++;
            if (imem_addr !== model_pc) begin
                errors++;
                $display("FAIL imem_addr cyc=%0d: got %h expected %h", cyc, imem_addr, model_pc);
            end
        end

        if (reset) begin
            exp_q.delete();
            model_pc = 32'h0;
            mem_busy = 1'b0;
        end else begin
            if (dec_valid === 1'b1 && dec_ready && !PC_clear && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cons_pc.push_back(e.pc);
            end
            if (drive_valid) begin
                if (!mem_discard && !PC_clear) begin
                    e.pc   = mem_addr_q;
                    e.data = mem_word(mem_addr_q);
                    exp_q.push_back(e);
                end
                mem_busy = 1'b0;
            end
            if (PC_clear) begin
                exp_q.delete();
                if (mem_busy) mem_discard = 1'b1;
                model_pc = PC_next & 32'hFFFF_FFFC;
            end else if (imem_req === 1'b1 && imem_ready) begin
                mem_busy    = 1'b1;
                mem_cnt     = mem_lat;
                mem_addr_q  = model_pc;
                mem_discard = 1'b0;
                acc_addr.push_back(model_pc);
                acc_cyc.push_back(cyc);
                model_pc = model_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        PC_clear   = 1'b0;
        PC_next    = 32'h0;
        dec_ready  = 1'b1;
        imem_ready = 1'b1;
        mem_lat    = 1;
        repeat (2) run_cycle();
        reset = 1'b0;
        cons_pc.delete();
        acc_addr.delete();
        acc_cyc.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin
            run_cycle();
            checks++;
            if (s_req !== 1'b0) begin
                errors++;
                $display("FAIL reset_req: got %b expected 0", s_req);
            end
            checks++;
            if (s_dvalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_dvalid: got %b expected 0", s_dvalid);
            end
        end
        reset = 1'b0;
        run_cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=0", s_req, s_addr);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        repeat (12) run_cycle();
        checks++;
        if (acc_addr.size() < 3 || acc_addr[0] !== 32'h0 || acc_addr[1] !== 32'h4 ||
            acc_addr[2] !== 32'h8) begin
            errors++;
            $display("FAIL stream_addrs: got %0d accepts expected 0,4,8 first", acc_addr.size());
        end
        checks++;
        if (acc_cyc.size() < 3 || (acc_cyc[1] - acc_cyc[0]) != 2 || (acc_cyc[2] - acc_cyc[1]) != 2) begin
            errors++;
            $display("FAIL stream_rate: got %0d accepts, expected one every 2 cycles", acc_cyc.size());
        end
        checks++;
        if (cons_pc.size() < 3 || cons_pc[0] !== 32'h0 || cons_pc[1] !== 32'h4 || cons_pc[2] !== 32'h8) begin
            errors++;
            $display("FAIL stream_pcs: got %0d consumed expected pc 0,4,8 first", cons_pc.size());
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        dec_ready = 1'b0;
        repeat (8) run_cycle();
        checks++;
        if (s_req !== 1'b0 || s_dvalid !== 1'b1 || s_dpc !== 32'h0 || acc_addr.size() != 2) begin
            errors++;
            $display("FAIL bp_full: got req=%b dvalid=%b dpc=%h accepts=%0d expected 0 1 0 2",
                     s_req, s_dvalid, s_dpc, acc_addr.size());
        end
        dec_ready = 1'b1;
        run_cycle();
        checks++;
        if (cons_pc.size() != 1 || cons_pc[0] !== 32'h0) begin
            errors++;
            $display("FAIL bp_pop: got %0d pops expected one pop of pc 0", cons_pc.size());
        end
        run_cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h8) begin
            errors++;
            $display("FAIL bp_resume: got req=%b addr=%h expected req=1 addr=8", s_req, s_addr);
        end
    endtask

    task automatic test_flush_fifo();
        apply_reset();
        dec_ready = 1'b0;
        repeat (6) run_cycle();
        PC_next  = 32'h100;
        PC_clear = 1'b1;
        run_cycle();
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_req_gated: got %b expected 0", s_req);
        end
        PC_clear = 1'b0;
        run_cycle();
        checks++;
        if (s_dvalid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h100) begin
            errors++;
            $display("FAIL flush_after: got dvalid=%b req=%b addr=%h expected 0 1 100",
                     s_dvalid, s_req, s_addr);
        end
        dec_ready = 1'b1;
        for (int i = 0; i < 12 && cons_pc.size() == 0; i++) run_cycle();
        checks++;
        if (cons_pc.size() == 0 || cons_pc[0] !== 32'h100) begin
            errors++;
            $display("FAIL flush_first_pc: got %0d pops expected first pc 100", cons_pc.size());
        end
    endtask

    task automatic test_flush_wait();
        apply_reset();
        mem_lat = 3;
        run_cycle();
        PC_next  = 32'h40;
        PC_clear = 1'b1;
        run_cycle();
        PC_clear = 1'b0;
        run_cycle();
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL drain_req: got %b expected 0", s_req);
        end
        run_cycle();
        run_cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h40) begin
            errors++;
            $display("FAIL drain_redirect: got req=%b addr=%h expected req=1 addr=40", s_req, s_addr);
        end
        for (int i = 0; i < 12 && cons_pc.size() == 0; i++) run_cycle();
        checks++;
        if (cons_pc.size() == 0 || cons_pc[0] !== 32'h40) begin
            errors++;
            $display("FAIL drain_first_pc: got %0d pops expected first pc 40", cons_pc.size());
        end
    endtask

    task automatic test_clear_with_valid();
        apply_reset();
        mem_lat = 2;
        run_cycle();
        run_cycle();
        PC_next  = 32'h103;
        PC_clear = 1'b1;
        run_cycle();
        PC_clear = 1'b0;
        run_cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h100) begin
            errors++;
            $display("FAIL clrvalid_addr: got req=%b addr=%h expected req=1 addr=100", s_req, s_addr);
        end
        for (int i = 0; i < 12 && cons_pc.size() == 0; i++) run_cycle();
        checks++;
        if (cons_pc.size() == 0 || cons_pc[0] !== 32'h100) begin
            errors++;
            $display("FAIL clrvalid_first_pc: got %0d pops expected first pc 100", cons_pc.size());
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        PC_next  = 32'hFFFF_FFFC;
        PC_clear = 1'b1;
        run_cycle();
        PC_clear = 1'b0;
        run_cycle();
        run_cycle();
        run_cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: got req=%b addr=%h expected req=1 addr=0", s_req, s_addr);
        end
        for (int i = 0; i < 12 && cons_pc.size() == 0; i++) run_cycle();
        checks++;
        if (cons_pc.size() == 0 || cons_pc[0] !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first_pc: got %0d pops expected first pc fffffffc", cons_pc.size());
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_cycle();
        PC_next  = 32'h200;
        PC_clear = 1'b1;
        run_cycle();
        PC_next  = 32'h300;
        run_cycle();
        PC_clear = 1'b0;
        run_cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h300) begin
            errors++;
            $display("FAIL b2b_clear: got req=%b addr=%h expected req=1 addr=300", s_req, s_addr);
        end
        repeat (6) run_cycle();
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        dec_ready = 1'b0;
        run_cycle();
        run_cycle();
        run_cycle();
        reset = 1'b1;
        run_cycle();
        checks++;
        if (s_req !== 1'b0 || s_dvalid !== 1'b0) begin
            errors++;
            $display("FAIL midwait_reset: got req=%b dvalid=%b expected 0 0", s_req, s_dvalid);
        end
        run_cycle();
        reset = 1'b0;
        run_cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0 || s_dvalid !== 1'b0) begin
            errors++;
            $display("FAIL midwait_restart: got req=%b addr=%h dvalid=%b expected 1 0 0",
                     s_req, s_addr, s_dvalid);
        end
        dec_ready = 1'b1;
        repeat (6) run_cycle();
    endtask

    initial begin
        reset      = 1'b1;
        PC_next    = 32'h0;
        PC_clear   = 1'b0;
        imem_ready = 1'b1;
        imem_valid = 1'b0;
        imem_data  = 32'h0;
        dec_ready  = 1'b1;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_fifo();
        test_flush_wait();
        test_clear_with_valid();
        test_wrap();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
